// File: rtl/mux4_arb_pkg.sv
// Shared types, constants and the rotating-priority search for the 4-way mux arbiter.
package mux4_arb_pkg;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned HOLD_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Returns {found, idx}; candidates are visited ptr+1 .. ptr+4 (mod 4).
    function automatic logic [IDX_W:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [IDX_W-1:0] ptr,
        input logic             exclude_en,
        input logic [IDX_W-1:0] exclude_idx
    );
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = ptr + IDX_W'(k);
            if (!found && req[cand] && !(exclude_en && (cand == exclude_idx))) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating priority encoder: first requester after ptr, optionally skipping one index.
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    input  logic             i_excl_en,
    input  logic [IDX_W-1:0] i_excl_idx,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W:0] w_pick;

    assign w_pick  = rr_pick(i_req, i_ptr, i_excl_en, i_excl_idx);
    assign o_found = w_pick[IDX_W];
    assign o_idx   = w_pick[IDX_W-1:0];

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select pair of a shared 4:1 mux.
// Optional forced handover after MAX_HOLD grant cycles when GRANT_TIMEOUT_EN is defined.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic             valid,
    output logic             s1,
    output logic             s2,
    output logic [IDX_W-1:0] owner
);

    state_t           r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [N_REQ-1:0] r_grant;
    logic             r_valid;
    logic [IDX_W-1:0] r_owner;

    state_t           w_next_state;
    logic [IDX_W-1:0] w_next_ptr;
    logic [N_REQ-1:0] w_next_grant;
    logic             w_next_valid;
    logic [IDX_W-1:0] w_next_owner;

    logic             w_excl_en;
    logic             w_found;
    logic [IDX_W-1:0] w_idx;
    logic             w_load;
    logic             w_idle;
    logic             w_timeout;

    // While granted the owner is always excluded; the result is only used on handover.
    assign w_excl_en = (r_state == GRANT);

    rr_pick4 u_pick (
        .i_req      (req),
        .i_ptr      (r_ptr),
        .i_excl_en  (w_excl_en),
        .i_excl_idx (r_owner),
        .o_found    (w_found),
        .o_idx      (w_idx)
    );

`ifdef GRANT_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_next_hold;

    assign w_timeout = (r_hold == HOLD_LIMIT);

    always_comb begin
        w_next_hold = r_hold;
        if (w_load || w_idle) begin
            w_next_hold = '0;
        end else if (r_state == GRANT) begin
            w_next_hold = w_timeout ? '0 : r_hold + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
        end else begin
            r_hold <= w_next_hold;
        end
    end
`else
    logic w_unused_max_hold;

    assign w_timeout         = 1'b0;
    assign w_unused_max_hold = ^(HOLD_W'(MAX_HOLD));
`endif

    // Next-state: IDLE picks on any request; GRANT hands over on owner release or timeout.
    always_comb begin
        w_next_state = r_state;
        w_next_ptr   = r_ptr;
        w_next_grant = r_grant;
        w_next_valid = r_valid;
        w_next_owner = r_owner;
        w_load       = 1'b0;
        w_idle       = 1'b0;

        case (r_state)
            IDLE: begin
                w_load = w_found;
            end
            GRANT: begin
                if (!req[r_owner]) begin
                    w_load = w_found;
                    w_idle = !w_found;
                end else if (w_timeout) begin
                    w_load = w_found;
                end
            end
            default: begin
                w_idle = 1'b1;
            end
        endcase

        if (w_load) begin
            w_next_state = GRANT;
            w_next_grant = N_REQ'(4'b0001 << w_idx);
            w_next_valid = 1'b1;
            w_next_owner = w_idx;
            w_next_ptr   = w_idx;
        end else if (w_idle) begin
            w_next_state = IDLE;
            w_next_grant = '0;
            w_next_valid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= IDX_W'(3);
            r_grant <= '0;
            r_valid <= 1'b0;
            r_owner <= '0;
        end else begin
            r_state <= w_next_state;
            r_ptr   <= w_next_ptr;
            r_grant <= w_next_grant;
            r_valid <= w_next_valid;
            r_owner <= w_next_owner;
        end
    end

    assign grant = r_grant;
    assign valid = r_valid;
    assign owner = r_owner;
    assign s1    = r_owner[1];
    assign s2    = r_owner[0];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: directed request vectors with hand-computed grants.
module tb_mux4_rr_arbiter;

`ifdef GRANT_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    typedef struct {
        string      name;
        logic [3:0] grant;
        logic       valid;
        logic [1:0] owner;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic       valid;
    logic       s1;
    logic       s2;
    logic [1:0] owner;
    logic [3:0] mux_in;
    logic       mux_out;

    exp_t q[$];
    int   n_checks;
    int   n_errors;
    event ev_async;

    mux4_rr_arbiter #(.MAX_HOLD(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .grant (grant),
        .valid (valid),
        .s1    (s1),
        .s2    (s2),
        .owner (owner)
    );

    // Behavioural stand-in for the shared 4:1 mux.
    assign mux_out = mux_in[{s1, s2}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input string nm, input logic [3:0] g, input logic v, input logic [1:0] o);
        exp_t e;
        e.name  = nm;
        e.grant = g;
        e.valid = v;
        e.owner = o;
        q.push_back(e);
    endtask

    task automatic step(input string nm, input logic [3:0] r, input logic [3:0] g,
                        input logic v, input logic [1:0] o);
        @(negedge clk);
        req = r;
        push_exp(nm, g, v, o);
    endtask

    // Monitor: one expectation per active edge (or async reset event).
    initial begin
        exp_t e;
        logic ok;
        logic exp_mux;
        forever begin
            @(posedge clk or ev_async);
            #1;
            if (q.size() > 0) begin
                e       = q.pop_front();
                exp_mux = mux_in[e.owner];
                ok = (grant === e.grant) && (valid === e.valid) && (owner === e.owner)
                     && ({s1, s2} === e.owner) && (!e.valid || (mux_out === exp_mux));
                n_checks++;
                if (!ok) begin
                    n_errors++;
                    $display("FAIL %s: got grant=%b valid=%b owner=%0d sel=%b%b mux=%b, expected grant=%b valid=%b owner=%0d",
                             e.name, grant, valid, owner, s1, s2, mux_out, e.grant, e.valid, e.owner);
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        req      = 4'b0000;
        mux_in   = 4'b0100;

        #3;
        push_exp("reset_state", 4'b0000, 1'b0, 2'd0);
        -> ev_async;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Grant 2, then async reset in the middle of the grant.
        step("pre_reset_grant", 4'b0100, 4'b0100, 1'b1, 2'd2);
        @(posedge clk);
        #3;
        rst = 1'b1;
        push_exp("reset_mid_grant", 4'b0000, 1'b0, 2'd0);
        -> ev_async;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        push_exp("reset_release", 4'b0001, 1'b1, 2'd0);

        // Rotation: each owner drops its request for one cycle.
        step("rot_1", 4'b1110, 4'b0010, 1'b1, 2'd1);
        step("rot_2", 4'b1101, 4'b0100, 1'b1, 2'd2);
        step("rot_3", 4'b1011, 4'b1000, 1'b1, 2'd3);
        step("rot_0", 4'b0111, 4'b0001, 1'b1, 2'd0);

        // Back-to-back handover 1 -> 3 without a bubble.
        step("b2b_grant1", 4'b1010, 4'b0010, 1'b1, 2'd1);
        step("b2b_hold1",  4'b1010, 4'b0010, 1'b1, 2'd1);
        step("b2b_to3",    4'b1000, 4'b1000, 1'b1, 2'd3);

        // Idle return keeps select at 11.
        step("idle_return", 4'b0000, 4'b0000, 1'b0, 2'd3);

        // Single requester 2 from idle; mux passes in2.
        step("single_req2",  4'b0100, 4'b0100, 1'b1, 2'd2);
        step("single_idle2", 4'b0000, 4'b0000, 1'b0, 2'd2);

        // Non-owner toggles during a grant are ignored.
        step("tog_grant0", 4'b0001, 4'b0001, 1'b1, 2'd0);
        step("tog_a",      4'b0011, 4'b0001, 1'b1, 2'd0);
        step("tog_b",      4'b0101, 4'b0001, 1'b1, 2'd0);
        step("tog_c",      4'b1001, 4'b0001, 1'b1, 2'd0);
        step("tog_d",      4'b0001, 4'b0001, 1'b1, 2'd0);
        step("tog_idle",   4'b0000, 4'b0000, 1'b0, 2'd0);

        // Simultaneous requests from idle with ptr=0.
        step("simul_pick1", 4'b0110, 4'b0010, 1'b1, 2'd1);
        step("simul_idle",  4'b0000, 4'b0000, 1'b0, 2'd1);

        // Lone owner holds well beyond 16 cycles.
        step("long_grant0", 4'b0001, 4'b0001, 1'b1, 2'd0);
        for (int i = 0; i < 20; i++) step("long_hold", 4'b0001, 4'b0001, 1'b1, 2'd0);
        step("long_idle", 4'b0000, 4'b0000, 1'b0, 2'd0);

        // Move ptr to 3 so the timeout run starts with owner 0.
        step("ptr_grant3", 4'b1000, 4'b1000, 1'b1, 2'd3);
        step("ptr_idle3",  4'b0000, 4'b0000, 1'b0, 2'd3);

        // Two contenders held: forced handover after 8 grant cycles only with the timeout.
        step("tmo_start", 4'b0011, 4'b0001, 1'b1, 2'd0);
        for (int i = 0; i < 7; i++) step("tmo_hold", 4'b0011, 4'b0001, 1'b1, 2'd0);
        step("tmo_edge", 4'b0011, TMO ? 4'b0010 : 4'b0001, 1'b1, TMO ? 2'd1 : 2'd0);
        for (int i = 0; i < 4; i++)
            step("tmo_after", 4'b0011, TMO ? 4'b0010 : 4'b0001, 1'b1, TMO ? 2'd1 : 2'd0);
        step("tmo_idle", 4'b0000, 4'b0000, 1'b0, TMO ? 2'd1 : 2'd0);

        repeat (2) @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter sharing one 4:1 mux (`mux4T01`) between four requesters.
- Accepts per-requester requests and issues a one-hot grant. Drives the mux select pair s1/s2 so the granted requester's input reaches the mux output.
- Sits directly in front of the mux; requester i owns mux input in{i}.

Parameters:
- N_REQ, 4, number of requesters; fixed at 4 (matches the mux arity); other values unsupported.
- MAX_HOLD, 8, maximum consecutive grant cycles before forced handover; used only when GRANT_TIMEOUT_EN is defined; legal range 2..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- req  input  4  request vector; bit i = requester i wants the mux
- grant  output  4  one-hot grant, registered; all-zero when idle
- valid  output  1  registered; high when any grant is active (OR of grant)
- s1  output  1  registered mux select MSB; equals owner index bit 1
- s2  output  1  registered mux select LSB; equals owner index bit 0
- owner  output  2  registered index of the current or last grantee

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: grant=4'b0000, valid=0, s1=0, s2=0, owner=2'd0, ptr=2'd3, state=IDLE, hold counter=0.
- ptr=3 at reset makes the first search start at requester 0.
- Reset asserted mid-grant clears all outputs immediately (asynchronously). First arbitration after release follows the reset ptr.
- Select mapping: {s1,s2}=owner. 00→in0, 01→in1, 10→in2, 11→in3.
- When not valid, s1/s2/owner hold their last value; the mux output is don't-care.
- Round-robin search: candidates are examined in order ptr+1, ptr+2, ptr+3, ptr+4, all modulo 4. The first requesting candidate wins. ptr is loaded with the winner on every new grant.
- State IDLE:
  - If req≠0, pick a winner. On the next edge: grant=onehot(winner), owner=winner, {s1,s2}=winner, valid=1, state→GRANT.
  - Latency from req high to grant: 1 cycle.
  - If req=0, stay in IDLE.
- State GRANT, owner still requesting (req[owner]=1): grant is held with no change. No preemption (but see Optional Feature).
- State GRANT, owner drops req: search with the owner excluded.
  - If another requester is found, grant moves directly to it on the next edge; no idle bubble.
  - Otherwise grant=0, valid=0 on the next edge, state→IDLE.
- Simultaneous requests: exactly one grant, chosen by the round-robin order. grant is never more than one-hot.
- Bits of req for non-owners that toggle during GRANT have no effect until handover.
- Fairness: each continuously requesting requester is granted within 3 handovers.

Optional Feature:
- Macro: GRANT_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter resets to 0 on every new grant and increments each cycle in GRANT.
  - When the counter reaches MAX_HOLD-1, another requester is pending, and req[owner] is still 1, the grant is forced to the next round-robin winner (owner excluded) on the next edge.
  - If no other requester is pending, the owner keeps the grant and the counter restarts at 0.
- Undefined: the counter logic is absent; MAX_HOLD is ignored; the owner holds the grant indefinitely while requesting.

Decomposition:
- Package mux4_arb_pkg:
  - state enum: IDLE=1'b0, GRANT=1'b1.
  - constant N_REQ=4.
  - function rr_pick(req, ptr, exclude_en, exclude_idx), returning {found, idx}.
- Sub-module rr_pick4: combinational rotating priority encoder. Inputs are req[3:0], ptr[1:0] and the exclusion mask; outputs are found and idx[1:0]. It is instantiated once by the arbiter FSM.
- The arbiter top module contains only the state register, ptr, the output registers and the optional counter.

Test Plan:
- Reset: assert rst=1 mid-cycle while grant=4'b0100 → grant=0, valid=0, {s1,s2}=00 immediately. After release with req=4'b1111 → grant=4'b0001 one edge later.
- Single requester: req=4'b0100 from IDLE → next edge grant=4'b0100, {s1,s2}=10. With mux in2=1 and other inputs 0, the mux output=1.
- Round-robin rotation:
  - req=4'b1111 held, each owner drops req for one cycle after its grant.
  - Grant sequence must be 0001→0010→0100→1000→0001; {s1,s2} steps 00,01,10,11.
- Back-to-back handover: owner 1 drops req while req=4'b1010 → next edge grant=4'b1000, valid stays 1 with no zero cycle.
- Idle return: sole owner 3 drops req with req=0 → next edge grant=0, valid=0, {s1,s2} stay 11.
- Timeout (GRANT_TIMEOUT_EN, MAX_HOLD=8):
  - req=4'b0011 held, owner 0 → grant moves to 4'b0010 after exactly 8 grant cycles.
  - With req=4'b0001 only, the grant holds for more than 16 cycles.
